// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and axis state encoding for the VGA timing generator.
package vga_timing_pkg;
    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {ST_ACT, ST_FRONT, ST_SYNC, ST_BACK} axis_st_e;

    // Advance one axis FSM given the counter value it is about to take.
    function automatic axis_st_e next_st(input axis_st_e st, input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] front_start,
                                         input logic [CNT_W-1:0] sync_start,
                                         input logic [CNT_W-1:0] back_start);
        axis_st_e nxt;
        nxt = st;
        case (st)
            ST_ACT:   if (cnt == front_start) nxt = ST_FRONT;
            ST_FRONT: if (cnt == sync_start)  nxt = ST_SYNC;
            ST_SYNC:  if (cnt == back_start)  nxt = ST_BACK;
            ST_BACK:  if (cnt == '0)          nxt = ST_ACT;
            default:  nxt = ST_ACT;
        endcase
        return nxt;
    endfunction
endpackage

// File: rtl/vga_timing_gen_pix_en.sv
// Clock divider: asserts tick on the clock where div_cnt reaches CLK_DIV-1.
module vga_pix_en_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rstn)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel strobe, counters, DE and HS/VS, all aligned on one edge.
// Optional VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter output o_frame_cnt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 5,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_de,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,output logic [7:0]      o_frame_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BS   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BS   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             tick;
    logic             h_wrap;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    axis_st_e         h_st, v_st, h_st_nxt, v_st_nxt;

    vga_pix_en_gen #(.CLK_DIV(CLK_DIV)) u_pix_en (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    always_comb begin
        h_wrap   = tick && (o_h_cnt == H_LAST);
        h_nxt    = o_h_cnt;
        v_nxt    = o_v_cnt;
        h_st_nxt = h_st;
        v_st_nxt = v_st;
        if (tick) begin
            h_nxt    = h_wrap ? '0 : o_h_cnt + 1'b1;
            h_st_nxt = next_st(h_st, h_nxt, H_FS, H_SS, H_BS);
        end
        if (h_wrap) begin
            v_nxt    = (o_v_cnt == V_LAST) ? '0 : o_v_cnt + 1'b1;
            v_st_nxt = next_st(v_st, v_nxt, V_FS, V_SS, V_BS);
        end
    end

    // Outputs decode the next-state values so every output moves with the counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_h_cnt       <= H_LAST;
            o_v_cnt       <= V_LAST;
            h_st          <= ST_BACK;
            v_st          <= ST_BACK;
            o_pix_en      <= 1'b0;
            o_de          <= 1'b0;
            o_hs          <= ~SYNC_POL;
            o_vs          <= ~SYNC_POL;
            o_frame_start <= 1'b0;
        end else begin
            o_h_cnt       <= h_nxt;
            o_v_cnt       <= v_nxt;
            h_st          <= h_st_nxt;
            v_st          <= v_st_nxt;
            o_pix_en      <= tick;
            o_de          <= (h_st_nxt == ST_ACT) && (v_st_nxt == ST_ACT);
            o_hs          <= (h_st_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            o_vs          <= (v_st_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            o_frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            o_frame_cnt <= '0;
        else if (tick && (h_nxt == '0) && (v_nxt == '0))
            o_frame_cnt <= o_frame_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default timing (CLK_DIV=5), a tiny raster for frame wrap, and CLK_DIV=1 full timing.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       de, hs, vs, pe, fs;
        logic [7:0] fc;
    } exp_t;
    typedef struct packed { exp_t x0, x1, x2; } sb_t;
    typedef struct { int e; exp_t x; } vec_t;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam logic [7:0] FC1 = 8'd1;
`else
    localparam logic [7:0] FC1 = 8'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
    logic       pe0, de0, hs0, vs0, fs0, pe1, de1, hs1, vs1, fs1, pe2, de2, hs2, vs2, fs2;
    logic [9:0] h0, v0, h1, v1, h2, v2;
    logic [7:0] fc0, fc1, fc2;

    vga_timing_gen #(.CLK_DIV(5)) d0 (
        .clk(clk), .rstn(rst0), .o_pix_en(pe0), .o_h_cnt(h0), .o_v_cnt(v0), .o_de(de0),
        .o_hs(hs0), .o_vs(vs0), .o_frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(fc0)
`endif
    );
    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) d1 (
        .clk(clk), .rstn(rst1), .o_pix_en(pe1), .o_h_cnt(h1), .o_v_cnt(v1), .o_de(de1),
        .o_hs(hs1), .o_vs(vs1), .o_frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(fc1)
`endif
    );
    vga_timing_gen #(.CLK_DIV(1)) d2 (
        .clk(clk), .rstn(rst2), .o_pix_en(pe2), .o_h_cnt(h2), .o_v_cnt(v2), .o_de(de2),
        .o_hs(hs2), .o_vs(vs2), .o_frame_start(fs2)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .o_frame_cnt(fc2)
`endif
    );
`ifndef VGA_TIMING_FRAME_CNT_EN
    assign fc0 = 8'd0;
    assign fc1 = 8'd0;
    assign fc2 = 8'd0;
`endif

    exp_t a0, a1, a2;
    assign a0 = {h0, v0, de0, hs0, vs0, pe0, fs0, fc0};
    assign a1 = {h1, v1, de1, hs1, vs1, pe1, fs1, fc1};
    assign a2 = {h2, v2, de2, hs2, vs2, pe2, fs2, fc2};

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Closed-form expectation from e = edges sampled with reset released.
    function automatic exp_t model(input int e, input int d, input int ha, input int hf,
                                   input int hsw, input int hb, input int va, input int vf,
                                   input int vsw, input int vb);
        exp_t x;
        int ht, vt, t, idx, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        t  = e / d;
        if (t == 0) begin
            x = {10'(ht - 1), 10'(vt - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        end else begin
            idx  = (t - 1) % (ht * vt);
            h    = idx % ht;
            v    = idx / ht;
            x.h  = 10'(h);
            x.v  = 10'(v);
            x.pe = (e % d) == 0;
            x.de = (h < ha) && (v < va);
            x.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
            x.vs = !((v >= va + vf) && (v < va + vf + vsw));
            x.fs = x.pe && (h == 0) && (v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            x.fc = 8'(((t - 1) / (ht * vt) + 1) % 256);
`else
            x.fc = 8'd0;
`endif
        end
        return x;
    endfunction

    function automatic exp_t mk(input int h, input int v, input bit de, input bit hs, input bit vs,
                                input bit pe, input bit fs, input logic [7:0] fc);
        return {10'(h), 10'(v), de, hs, vs, pe, fs, fc};
    endfunction

    initial begin
        vec_t tbl[12];
        sb_t  q[$];
        sb_t  sb;
        int   e0 = 0, e1 = 0, e2 = 0, cyc = 0;
        int   lo0 = 0, lo2 = 0, last0 = -1, last2 = -1, lastf1 = -1;
        bit   did_rst = 0;

        tbl[0]  = '{4,    mk(799, 524, 0, 1, 1, 0, 0, 8'd0)};
        tbl[1]  = '{5,    mk(0,   0,   1, 1, 1, 1, 1, FC1)};
        tbl[2]  = '{6,    mk(0,   0,   1, 1, 1, 0, 0, FC1)};
        tbl[3]  = '{10,   mk(1,   0,   1, 1, 1, 1, 0, FC1)};
        tbl[4]  = '{3200, mk(639, 0,   1, 1, 1, 1, 0, FC1)};
        tbl[5]  = '{3205, mk(640, 0,   0, 1, 1, 1, 0, FC1)};
        tbl[6]  = '{3285, mk(656, 0,   0, 0, 1, 1, 0, FC1)};
        tbl[7]  = '{3760, mk(751, 0,   0, 0, 1, 1, 0, FC1)};
        tbl[8]  = '{3765, mk(752, 0,   0, 1, 1, 1, 0, FC1)};
        tbl[9]  = '{4000, mk(799, 0,   0, 1, 1, 1, 0, FC1)};
        tbl[10] = '{4005, mk(0,   1,   1, 1, 1, 1, 0, FC1)};
        tbl[11] = '{4007, mk(0,   1,   1, 1, 1, 0, 0, FC1)};

        @(posedge clk); #1;
        chk("reset_h", 64'(h0), 64'd799);
        chk("reset_v", 64'(v0), 64'd524);
        chk("reset_sync", 64'({hs0, vs0}), 64'd3);
        chk("reset_de_pe_fs", 64'({de0, pe0, fs0}), 64'd0);

        while (e1 < 256 * 128 + 20) begin
            @(negedge clk);
            rst0 = !(!did_rst && e0 == 5505);
            if (!rst0) did_rst = 1;
            rst1 = 1'b1;
            rst2 = 1'b1;
            e0 = rst0 ? e0 + 1 : 0;
            e1++;
            e2++;
            q.push_back({model(e0, 5, 640, 16, 96, 48, 480, 10, 2, 33),
                         model(e1, 1, 8, 2, 3, 3, 4, 1, 2, 1),
                         model(e2, 1, 640, 16, 96, 48, 480, 10, 2, 33)});
            @(posedge clk); #1;
            cyc++;
            sb = q.pop_front();
            chk("sb_d0", 64'(a0), 64'(sb.x0));
            chk("sb_d1", 64'(a1), 64'(sb.x1));
            chk("sb_d2", 64'(a2), 64'(sb.x2));
            foreach (tbl[k])
                if (tbl[k].e == e0) chk($sformatf("vec_e%0d", tbl[k].e), 64'(a0), 64'(tbl[k].x));

            if (!did_rst && e0 == 5505) chk("pre_rst_pos", 64'({h0, v0}), 64'({10'd300, 10'd1}));
            if (did_rst && e0 == 0)
                chk("mid_rst", 64'({h0, v0, hs0, vs0, de0, pe0}), 64'({10'd799, 10'd524, 4'b1100}));
            if (did_rst && e0 == 5)
                chk("restart_first", 64'({h0, v0, de0, pe0, fs0}), 64'({20'd0, 3'b111}));

            if (!hs0) lo0++;
            else begin
                if (lo0 != 0) chk("hs_low_d0", 64'(lo0), 64'd480);
                lo0 = 0;
            end
            if (!hs2) lo2++;
            else begin
                if (lo2 != 0) chk("hs_low_d2", 64'(lo2), 64'd96);
                lo2 = 0;
            end
            if (e0 == 0) last0 = -1;
            if (pe0 && h0 == 10'd0) begin
                if (last0 >= 0) chk("line_period_d0", 64'(cyc - last0), 64'd4000);
                last0 = cyc;
            end
            if (pe2 && h2 == 10'd0) begin
                if (last2 >= 0) chk("line_period_d2", 64'(cyc - last2), 64'd800);
                last2 = cyc;
            end
            if (fs1) begin
                if (lastf1 >= 0) chk("frame_period_d1", 64'(cyc - lastf1), 64'd128);
                lastf1 = cyc;
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (e1 == 1) chk("fc_first", 64'(fc1), 64'd1);
            if (e1 == 255 * 128 + 1) chk("fc_wrap", 64'({fs1, fc1}), 64'h100);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
